// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver front end: 2-flop sync, mid-bit sampling, framing-error/break handling.
// Define UART_PARITY_EN to add an even-parity bit after the data bits and the parity_err port.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       frame_err,
    output logic       rx_busy
`ifdef UART_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_status_q, rx_status_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_busy_q;
    logic                 last_tick;
`ifdef UART_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    assign last_tick = (tcnt_q == TW'(OVERSAMPLE - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_status_q <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            sync1_q     <= uart_rx;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_status_q <= rx_status_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= (state_d != S_IDLE);
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tcnt_d      = tcnt_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_status_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tcnt_d  = '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in; a high level means the edge was a glitch.
                    if (tcnt_q == TW'(OVERSAMPLE / 2 - 1)) begin
                        tcnt_d = '0;
                        bcnt_d = '0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_tick) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tcnt_d  = '0;
                        bcnt_d  = bcnt_q + 1'b1;
                        if (bcnt_q == BW'(DATA_BITS - 1)) begin
                            bcnt_d = '0;
`ifdef UART_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (last_tick) begin
                        par_d   = rx_s_q;
                        tcnt_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (last_tick) begin
                        tcnt_d = '0;
                        if (rx_s_q) begin
                            rx_data_d   = 8'(shift_q);
                            rx_status_d = 1'b1;
                            state_d     = S_IDLE;
`ifdef UART_PARITY_EN
                            parity_err_d = (^shift_q) ^ par_q;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_status = rx_status_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;
`ifdef UART_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler (OVERSAMPLE=16, DATA_BITS=8, baud_tick every 4 clk_sys).
// Parity scenarios are compiled in only when UART_PARITY_EN is defined.
module tb_uart_rx_sampler;
    localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk_sys per bit

    logic       clk_sys   = 1'b0;
    logic       reset     = 1'b1;
    logic       baud_tick = 1'b0;
    logic       uart_rx   = 1'b1;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       frame_err;
    logic       rx_busy;
`ifdef UART_PARITY_EN
    logic       parity_err;
    logic       last_perr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    int         status_cnt  = 0;
    int         ferr_cnt    = 0;
    int         width_bad   = 0;
    int         busy_bad    = 0;
    logic       status_prev = 1'b0;
    logic [7:0] data_log [0:15];

    uart_rx_sampler #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .baud_tick (baud_tick),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
`ifdef UART_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    initial begin : tick_gen
        int n;
        n = 0;
        forever begin
            @(negedge clk_sys);
            n = (n + 1) % 4;
            baud_tick = (n == 0);
        end
    end

    // Pulse monitor: logs each received byte and flags multi-cycle or overlapping pulses.
    always @(negedge clk_sys) begin
        if (rx_status === 1'b1) begin
            if (status_prev) width_bad++;
            if (rx_busy !== 1'b0 || frame_err !== 1'b0) busy_bad++;
            data_log[status_cnt % 16] = rx_data;
`ifdef UART_PARITY_EN
            last_perr = parity_err;
`endif
            status_cnt++;
        end
        status_prev = (rx_status === 1'b1);
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_rest(input logic [7:0] d, input logic stop);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        send_rest(d, stop);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clks(3);
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_status !== 1'b0) begin errors++; $display("FAIL reset_rx_status: got %b expected 0", rx_status); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
        reset = 1'b0;
        wait_clks(BIT_CLKS);
        checks++; if (status_cnt !== 0) begin errors++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", status_cnt); end
    endtask

    task automatic test_normal;
        int s0, f0, w0, b0;
        s0 = status_cnt; f0 = ferr_cnt; w0 = width_bad; b0 = busy_bad;
        drive_bit(1'b0);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL normal_busy_mid: got %b expected 1", rx_busy); end
        send_rest(8'h5A, 1'b1);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 1) begin errors++; $display("FAIL normal_pulses: got %0d expected 1", status_cnt - s0); end
        checks++; if (data_log[s0 % 16] !== 8'h5A) begin errors++; $display("FAIL normal_data_at_pulse: got %h expected 5a", data_log[s0 % 16]); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL normal_rx_data: got %h expected 5a", rx_data); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL normal_frame_err: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (width_bad !== w0) begin errors++; $display("FAIL normal_pulse_width: got %0d wide pulses expected 0", width_bad - w0); end
        checks++; if (busy_bad !== b0) begin errors++; $display("FAIL normal_busy_at_pulse: got %0d expected 0", busy_bad - b0); end
    endtask

    task automatic test_glitch;
        int s0, f0;
        s0 = status_cnt; f0 = ferr_cnt;
        uart_rx = 1'b0;
        wait_clks(12);
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b expected 1", rx_busy); end
        uart_rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_back_idle: got %b expected 0", rx_busy); end
        checks++; if (status_cnt - s0 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", status_cnt - s0); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", ferr_cnt - f0); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_rx_data: got %h expected 5a", rx_data); end
    endtask

    task automatic test_framing;
        int s0, f0;
        s0 = status_cnt; f0 = ferr_cnt;
        send_frame(8'hFF, 1'b0);
        wait_clks(20 * BIT_CLKS);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL framing_err_pulses: got %0d expected 1", ferr_cnt - f0); end
        checks++; if (status_cnt - s0 !== 0) begin errors++; $display("FAIL framing_no_status: got %0d expected 0", status_cnt - s0); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL framing_rx_data_held: got %h expected 5a", rx_data); end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL framing_break_busy: got %b expected 1", rx_busy); end
        uart_rx = 1'b1;
        wait_clks(BIT_CLKS);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL framing_break_exit: got %b expected 0", rx_busy); end
        send_frame(8'h01, 1'b1);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 1) begin errors++; $display("FAIL framing_recover_pulses: got %0d expected 1", status_cnt - s0); end
        checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL framing_recover_data: got %h expected 01", rx_data); end
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL framing_err_total: got %0d expected 1", ferr_cnt - f0); end
    endtask

    task automatic test_back_to_back;
        int s0, f0;
        logic [7:0] exp_bytes [0:2];
        exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF; exp_bytes[2] = 8'h81;
        s0 = status_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", status_cnt - s0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (data_log[(s0 + i) % 16] !== exp_bytes[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, data_log[(s0 + i) % 16], exp_bytes[i]);
            end
        end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cnt - f0); end
    endtask

    task automatic test_reset_mid_frame;
        int s0, f0;
        logic [7:0] half;
        half = 8'h55;
        s0 = status_cnt; f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(half[i]);
        reset   = 1'b1;
        uart_rx = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midreset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midreset_rx_busy: got %b expected 0", rx_busy); end
        wait_clks(BIT_CLKS);
        send_frame(8'hA3, 1'b1);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 1) begin errors++; $display("FAIL midreset_pulses: got %0d expected 1", status_cnt - s0); end
        checks++; if (data_log[s0 % 16] !== 8'hA3) begin errors++; $display("FAIL midreset_data: got %h expected a3", data_log[s0 % 16]); end
        checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midreset_frame_err: got %0d expected 0", ferr_cnt - f0); end
    endtask

`ifdef UART_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask

    task automatic test_parity;
        int s0;
        s0 = status_cnt;
        send_frame_par(8'h07, 1'b1);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 1) begin errors++; $display("FAIL parity_good_pulses: got %0d expected 1", status_cnt - s0); end
        checks++; if (last_perr !== 1'b0) begin errors++; $display("FAIL parity_good_err: got %b expected 0", last_perr); end
        send_frame_par(8'h07, 1'b0);
        wait_clks(4);
        checks++; if (status_cnt - s0 !== 2) begin errors++; $display("FAIL parity_bad_pulses: got %0d expected 2", status_cnt - s0); end
        checks++; if (last_perr !== 1'b1) begin errors++; $display("FAIL parity_bad_err: got %b expected 1", last_perr); end
        checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL parity_bad_data: got %h expected 07", rx_data); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_err_one_cycle: got %b expected 0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
